// File: rtl/dibit_pixel_deserializer_pkg.sv
// Shared frame-streaming format definitions.
// Used by both the transmitter and this receiver so both ends agree on the
// packet layout: a 3-byte start address followed by a run of pixel bytes,
// each byte carried as 4 dibits.
package dibit_pixel_deserializer_pkg;

  localparam int unsigned FramePixels     = 76800;
  localparam int unsigned PixelsPerPacket = 320;
  localparam int unsigned AddrBytes       = 3;
  localparam int unsigned DibitsPerByte   = 4;
  localparam int unsigned AddrDibits      = AddrBytes * DibitsPerByte;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StPixel,
    StSkip
  } state_e;

endpackage

// File: rtl/dibit_pixel_deserializer_if.sv
// Stream-in / frame-buffer-write bundle for the dibit pixel deserializer.
// master: drives the dibit stream and observes writes/status (stream source side).
// slave : consumes the dibit stream and drives the frame-buffer write port.
//   axiiv/axiid             dibit valid and data
//   wr_en/wr_addr/wr_data   frame-buffer write port
//   packet_done/packet_err  one-cycle packet status pulses
//   busy                    receiver is mid-packet (address or pixel phase)
interface dibit_pixel_deserializer_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              axiiv;
  logic [1:0]        axiid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              packet_done;
  logic              packet_err;
  logic              busy;

  modport master (
    output axiiv, axiid,
    input  wr_en, wr_addr, wr_data, packet_done, packet_err, busy
  );

  modport slave (
    input  axiiv, axiid,
    output wr_en, wr_addr, wr_data, packet_done, packet_err, busy
  );
endinterface

// File: rtl/dibit_pixel_deserializer_byte_assembler.sv
// Collects four dibits, LSB pair first, into one byte.
//   clk, rst      clock and synchronous active-high reset
//   i_valid       a dibit is present this cycle
//   i_clear       drop any partial byte and restart at position 0
//   i_dibit       incoming dibit
//   o_byte        assembled byte (valid only with o_byte_valid)
//   o_byte_valid  high combinationally on the 4th dibit of a byte
module dibit_pixel_deserializer_byte_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic       i_clear,
  input  logic [1:0] i_dibit,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  logic [1:0] r_pos;
  logic [5:0] r_shift;

  // New dibits enter at the top so the first one ends up in bits [1:0].
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_pos   <= 2'd0;
      r_shift <= 6'd0;
    end else if (i_valid) begin
      r_pos   <= r_pos + 2'd1;
      r_shift <= {i_dibit, r_shift[5:2]};
    end
  end

  assign o_byte       = {i_dibit, r_shift};
  assign o_byte_valid = i_valid && !i_clear && (r_pos == 2'd3);

endmodule

// File: rtl/dibit_pixel_deserializer.sv
// Receive-side frame-stream deserializer.
// Recovers a 24-bit start address and PIXELS_PER_PACKET pixel bytes from a
// 2-bit-per-cycle stream and issues one frame-buffer write per pixel.
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of dibit_pixel_deserializer_if (stream in, writes out)
module dibit_pixel_deserializer
  import dibit_pixel_deserializer_pkg::*;
#(
  parameter int unsigned PIXELS_PER_PACKET = PixelsPerPacket,
  parameter int unsigned FRAME_PIXELS      = FramePixels,
  parameter int unsigned ADDR_W            = 17
) (
  input logic                      clk,
  input logic                      rst,
  dibit_pixel_deserializer_if.slave bus
);

  localparam int unsigned PixCntW = $clog2(PIXELS_PER_PACKET + 1);

  state_e              r_state;
  logic [3:0]          r_addr_dibit_cnt;
  logic [15:0]         r_addr_hi;
  logic [PixCntW-1:0]  r_pix_cnt;
  logic [ADDR_W-1:0]   r_pix_addr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_packet_done;
  logic                r_packet_err;

  logic [7:0]          w_byte;
  logic                w_byte_valid;
  logic                w_asm_valid;
  logic                w_asm_clear;
  logic [31:0]         w_addr_full;
  logic                w_addr_ok;
  logic [ADDR_W-1:0]   w_pix_addr_next;

  // The SKIP phase and any idle cycle must leave the assembler at position 0.
  assign w_asm_valid = bus.axiiv && (r_state != StSkip);
  assign w_asm_clear = !bus.axiiv || (r_state == StSkip);

  dibit_pixel_deserializer_byte_assembler u_byte_asm (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (w_asm_valid),
    .i_clear      (w_asm_clear),
    .i_dibit      (bus.axiid),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid)
  );

  // Address bytes arrive MSB first; the third byte is still on the assembler output.
  assign w_addr_full     = {8'd0, r_addr_hi, w_byte};
  assign w_addr_ok       = w_addr_full < FRAME_PIXELS;
  assign w_pix_addr_next = (r_pix_addr == ADDR_W'(FRAME_PIXELS - 1)) ? '0
                                                                     : r_pix_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= StIdle;
      r_addr_dibit_cnt <= 4'd0;
      r_addr_hi        <= 16'd0;
      r_pix_cnt        <= '0;
      r_pix_addr       <= '0;
      r_wr_en          <= 1'b0;
      r_wr_addr        <= '0;
      r_wr_data        <= 8'd0;
      r_packet_done    <= 1'b0;
      r_packet_err     <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_packet_done <= 1'b0;
      r_packet_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // The first valid cycle is already address dibit 0.
          if (bus.axiiv) begin
            r_state          <= StAddr;
            r_addr_dibit_cnt <= 4'd1;
          end
        end
        StAddr: begin
          if (!bus.axiiv) begin
            r_packet_err     <= 1'b1;
            r_addr_dibit_cnt <= 4'd0;
            r_state          <= StIdle;
          end else begin
            r_addr_dibit_cnt <= r_addr_dibit_cnt + 4'd1;
            if (w_byte_valid) r_addr_hi <= {r_addr_hi[7:0], w_byte};
            if (r_addr_dibit_cnt == 4'(AddrDibits - 1)) begin
              r_addr_dibit_cnt <= 4'd0;
              if (w_addr_ok) begin
                r_pix_addr <= w_addr_full[ADDR_W-1:0];
                r_pix_cnt  <= '0;
                r_state    <= StPixel;
              end else begin
                r_packet_err <= 1'b1;
                r_state      <= StSkip;
              end
            end
          end
        end
        StPixel: begin
          if (!bus.axiiv) begin
            r_packet_err <= 1'b1;
            r_state      <= StIdle;
          end else if (w_byte_valid) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_pix_addr;
            r_wr_data  <= w_byte;
            r_pix_addr <= w_pix_addr_next;
            r_pix_cnt  <= r_pix_cnt + PixCntW'(1);
            if (r_pix_cnt == PixCntW'(PIXELS_PER_PACKET - 1)) begin
              r_packet_done <= 1'b1;
              r_state       <= StSkip;
            end
          end
        end
        StSkip: begin
          if (!bus.axiiv) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.packet_done = r_packet_done;
  assign bus.packet_err  = r_packet_err;
  assign bus.busy        = (r_state == StAddr) || (r_state == StPixel);

endmodule

// File: tb/tb_dibit_pixel_deserializer.sv
// Bench for dibit_pixel_deserializer: packets are built as byte lists, serialized
// to dibits, and the expected write list is derived from the packet bytes and the
// number of dibits actually sent.
module tb_dibit_pixel_deserializer;

  localparam int unsigned PPP = 320;
  localparam int unsigned FP  = 76800;
  localparam int unsigned AW  = 17;

  typedef logic [AW+7:0] wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dibit_pixel_deserializer_if #(.ADDR_W(AW)) bus ();

  dibit_pixel_deserializer #(
    .PIXELS_PER_PACKET (PPP),
    .FRAME_PIXELS      (FP),
    .ADDR_W            (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  wr_t        act_q[$];
  wr_t        exp_q[$];
  int         wr_cyc_q[$];
  logic [7:0] pkt[$];
  int         act_done = 0, act_err = 0, exp_done = 0, exp_err = 0;
  int         pulse_viol = 0;
  int         cyc = 0;
  logic       prev_wr = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (bus.wr_en) begin
        act_q.push_back({bus.wr_addr, bus.wr_data});
        wr_cyc_q.push_back(cyc);
      end
      if (bus.packet_done) begin
        act_done++;
        if (!bus.wr_en) pulse_viol++;
      end
      if (bus.packet_err) act_err++;
      if ((bus.wr_en && prev_wr) || (bus.packet_done && prev_done) ||
          (bus.packet_err && prev_err)) pulse_viol++;
      prev_wr   = bus.wr_en;
      prev_done = bus.packet_done;
      prev_err  = bus.packet_err;
    end
  end

  task automatic build_packet(input int unsigned addr, input int npix, input bit rand_pix);
    pkt.delete();
    pkt.push_back(addr[23:16]);
    pkt.push_back(addr[15:8]);
    pkt.push_back(addr[7:0]);
    for (int i = 0; i < npix; i++) pkt.push_back(rand_pix ? 8'($urandom) : 8'(i % 64));
  endtask

  // Sends nd dibits, then holds axiiv low for gap cycles (gap >= 1).
  task automatic send(input int nd, input int gap);
    logic [7:0] b;
    while (pkt.size() * 4 < nd) pkt.push_back(8'($urandom));
    for (int i = 0; i < nd; i++) begin
      @(posedge clk); #1;
      b         = pkt[i/4];
      bus.axiiv = 1'b1;
      bus.axiid = b[2*(i%4) +: 2];
    end
    @(posedge clk); #1;
    bus.axiiv = 1'b0;
    bus.axiid = 2'd0;
    repeat (gap - 1) @(posedge clk);
  endtask

  // Expected outcome of a packet of which nd dibits were sent before axiiv dropped.
  task automatic model_packet(input int nd);
    int unsigned addr;
    int          nfull;
    if (nd < 12) begin
      if (nd > 0) exp_err++;
      return;
    end
    addr = {8'd0, pkt[0], pkt[1], pkt[2]};
    if (addr >= FP) begin
      exp_err++;
      return;
    end
    nfull = (nd - 12) / 4;
    if (nfull > int'(PPP)) nfull = PPP;
    for (int i = 0; i < nfull; i++) exp_q.push_back({AW'((addr + i) % FP), pkt[3+i]});
    if (nfull == int'(PPP)) exp_done++;
    else exp_err++;
  endtask

  task automatic check_all(input string tag);
    int nbad, first, n;
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, ":nwr"}, act_q.size(), exp_q.size());
    nbad  = 0;
    first = -1;
    n     = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (act_q[i] !== exp_q[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) check_eq({tag, ":wr_first"}, act_q[first], exp_q[first]);
    check_eq({tag, ":wr_bad"}, nbad, 0);
    check_eq({tag, ":done"}, act_done, exp_done);
    check_eq({tag, ":err"}, act_err, exp_err);
    check_eq({tag, ":busy"}, bus.busy, 1'b0);
    check_eq({tag, ":pulses"}, pulse_viol, 0);
    act_q.delete();
    exp_q.delete();
    wr_cyc_q.delete();
    act_done = 0; act_err = 0; exp_done = 0; exp_err = 0; pulse_viol = 0;
  endtask

  initial begin
    int unsigned addr;
    int          nd, bad, sel;

    bus.axiiv = 1'b0;
    bus.axiid = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.packet_done,
                            bus.packet_err, bus.busy}, '0);
    rst = 1'b0;

    // 1: normal packet at address 0, ramp pixels
    build_packet(0, PPP, 1'b0);
    nd = 12 + 4 * PPP;
    send(nd, 1);
    model_packet(nd);
    bad = 0;
    for (int i = 1; i < wr_cyc_q.size(); i++) if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) bad++;
    check_eq("t1:gap4", bad, 0);
    check_all("t1");

    // 2a: address 76800 rejected
    build_packet(32'h012C00, 4, 1'b1);
    nd = 12 + 16;
    send(nd, 1);
    model_packet(nd);
    check_all("t2a");

    // 2b: address 76799, two pixels then abort; wraps to 0
    build_packet(32'h012BFF, 2, 1'b1);
    nd = 12 + 8;
    send(nd, 1);
    model_packet(nd);
    check_all("t2b");

    // 3: abort after 2 dibits of pixel 5, then a normal packet
    build_packet(0, PPP, 1'b1);
    nd = 12 + 5 * 4 + 2;
    send(nd, 1);
    model_packet(nd);
    check_all("t3a");
    build_packet($urandom_range(0, FP - 1), PPP, 1'b1);
    nd = 12 + 4 * PPP;
    send(nd, 1);
    model_packet(nd);
    check_all("t3b");

    // 4: 64 trailing bytes ignored
    build_packet(1000, PPP + 64, 1'b1);
    nd = 12 + 4 * (PPP + 64);
    send(nd, 1);
    model_packet(nd);
    check_all("t4");

    // 5: reset after 7 address dibits, then address 100
    build_packet(32'h00ABCD, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.axiiv = 1'b1;
      bus.axiid = 2'($urandom);
    end
    @(posedge clk); #1;
    check_eq("t5:busy_addr", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5:rst_outs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.packet_done,
                             bus.packet_err, bus.busy}, '0);
    bus.axiiv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("t5a");
    build_packet(100, PPP, 1'b1);
    nd = 12 + 4 * PPP;
    send(nd, 1);
    model_packet(nd);
    check_all("t5b");

    // 6: back-to-back packets, one idle cycle apart
    build_packet(0, PPP, 1'b1);
    nd = 12 + 4 * PPP;
    send(nd, 1);
    model_packet(nd);
    build_packet(PPP, PPP, 1'b1);
    send(nd, 1);
    model_packet(nd);
    check_all("t6");

    // Randomized packets: valid, near-wrap and out-of-range addresses, full or aborted.
    for (int k = 0; k < 8; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       addr = $urandom_range(0, FP - 1);
        1:       addr = FP - 1 - $urandom_range(0, 5);
        2:       addr = FP + $urandom_range(0, 24'hFFFFFF - FP);
        default: addr = $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 1) == 1) nd = 12 + 4 * PPP + $urandom_range(0, 40);
      else nd = $urandom_range(1, 12 + 4 * PPP - 1);
      build_packet(addr, 0, 1'b1);
      send(nd, $urandom_range(1, 3));
      model_packet(nd);
      check_all($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dibit_pixel_deserializer.md
Name: dibit_pixel_deserializer

Overview:
Receive-side counterpart of the frame-streaming transmitter. It consumes a 2-bit-per-cycle valid/data stream and recovers a 24-bit start address, then PIXELS_PER_PACKET 8-bit pixels. It issues one frame-buffer BRAM write per recovered pixel. It sits between the Ethernet/RMII receive path and the display frame buffer.

Parameters:
PIXELS_PER_PACKET, 320, pixel bytes that follow the address in one packet
FRAME_PIXELS, 76800, frame-buffer depth; valid addresses are 0..FRAME_PIXELS-1
ADDR_W, 17, width of the frame-buffer write address

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
axiiv  in  1  input dibit valid; high for the whole packet
axiid  in  2  input dibit
wr_en  out  1  frame-buffer write strobe, one cycle per pixel
wr_addr  out  ADDR_W  frame-buffer write address
wr_data  out  8  pixel byte to write
packet_done  out  1  one-cycle pulse when the last pixel of a packet is written
packet_err  out  1  one-cycle pulse when a packet is aborted or rejected
busy  out  1  high while in ADDR or PIXEL state

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-packet discards everything; the packet is not resumed.
- Wire format: bytes are sent MSB byte first. Within each byte, dibits are sent LSB pair first: dibit k carries bits [2k+1:2k], for k = 0..3.
- Address: 3 bytes = 12 dibits, forming addr[23:0]. Pixels: 4 dibits each.
- IDLE: on axiiv=1, capture the dibit as address dibit 0 and go to ADDR. The first valid cycle is data.
- ADDR: shift in dibits; after dibit 11, check addr[23:0] < FRAME_PIXELS.
  - Pass: load pix_addr = addr[ADDR_W-1:0], clear the pixel counter, go to PIXEL.
  - Fail: pulse packet_err, go to SKIP.
- PIXEL: assemble a byte over 4 dibits.
  - The cycle after the 4th dibit: wr_en=1, wr_data=byte, wr_addr=pix_addr. Latency is 1 cycle from last dibit to write.
  - After each write, pix_addr increments; FRAME_PIXELS-1 wraps to 0.
  - Back-to-back pixels produce wr_en every 4th cycle.
  - After pixel PIXELS_PER_PACKET-1: packet_done pulses in the same cycle as its wr_en, then go to SKIP.
- SKIP: ignore dibits, e.g. trailing audio bytes, until axiiv=0, then go to IDLE.
- axiiv=0 while in ADDR or PIXEL:
  - Abort the packet, pulse packet_err, go to IDLE.
  - Discard any partial byte; pixels already written stay written.
  - If a completed byte's write is pending on that same cycle, the write still occurs.
- Gaps: there are no gaps inside a packet; any deassertion is an abort.
- Minimum spacing: one cycle of axiiv=0 between packets; the next high cycle starts a new address.
- Registered outputs: wr_en, packet_done and packet_err are never high for more than one consecutive cycle each. wr_addr and wr_data hold their last values when wr_en=0.
- Counters:
  - Dibit counter is 2 bits and wraps naturally.
  - Address dibit counter is 4 bits (0..11).
  - Pixel counter is 9 bits, sized with clog2(PIXELS_PER_PACKET+1).

Decomposition:
- Shared package frame_stream_pkg:
  - state enum {IDLE, ADDR, PIXEL, SKIP}
  - constants FRAME_PIXELS=76800, PIXELS_PER_PACKET=320, ADDR_BYTES=3, DIBITS_PER_BYTE=4
  - The transmitter also uses these constants, so both ends agree on the format.
- Sub-module dibit_byte_assembler:
  - Holds the 2-bit position counter and the shift register.
  - Emits byte + byte_valid on the 4th dibit and clears on a clear input.
  - Reused for both address bytes and pixel bytes.

Test Plan:
1. Normal packet: address 0x000000, then pixels 0x00..0x3F repeating for 320 bytes, axiiv held the whole time -> 320 writes at addr 0..319 with matching data, writes 4 cycles apart, packet_done with the 320th write, no packet_err.
2. Dibit order: address bytes 0x01,0x2C,0x00 (addr 76800), sent as dibits 01,00,00,00 / 00,11,10,00 / 00,00,00,00 -> rejected: packet_err pulse, zero writes. Same test with 0x01,0x2B,0xFF (76799) and 2 pixels -> writes at 76799 then 0, then abort err when axiiv drops.
3. Abort mid-pixel: drop axiiv after 2 dibits of pixel 5 -> writes 0..4 only, packet_err one cycle, busy=0; the next packet is received normally.
4. Trailing data: 320 pixels plus 64 extra bytes with axiiv high -> exactly 320 writes, extras ignored, IDLE after axiiv falls, no err.
5. Reset mid-ADDR after 7 address dibits, then a full packet with address 100 -> no writes before reset, all outputs 0 during reset, then writes 100..419.
6. Back-to-back packets with a 1-cycle gap, addresses 0 and 320 -> 640 contiguous writes, two packet_done pulses.
